// File: rtl/suma_c2.sv
// suma_c2: registered two's-complement adder with carry-in, carry-out and
// signed-overflow flag. The sum ripples through a chain of full-adder cells,
// and the outputs are registered once per clock.

// Single-bit full-adder cell. It is the building block of the ripple chain.
module suma_c2_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and majority-carry of the three input bits
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

module suma_c2 #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic             ci,
    output logic [ANCHO-1:0] s,
    output logic             coutfin,
    output logic             desb
);

    // carry[i] is the carry into cell i; carry[ANCHO] leaves the MSB cell
    logic [ANCHO:0]   carry;
    logic [ANCHO-1:0] s_next;
    logic             coutfin_next;
    logic             desb_next;

    assign carry[0] = ci;

    // Ripple chain of ANCHO full-adder cells, LSB first
    for (genvar i = 0; i < ANCHO; i++) begin : g_cell
        suma_c2_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (s_next[i]),
            .co (carry[i+1])
        );
    end

    // Signed overflow occurs exactly when the carries into and out of the
    // sign cell disagree, which is the same as the operand/result sign rule
    always_comb begin
        coutfin_next = carry[ANCHO];
        desb_next    = carry[ANCHO] ^ carry[ANCHO-1];
    end

    // Output registers; synchronous reset wins over any operand value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s       <= '0;
            coutfin <= 1'b0;
            desb    <= 1'b0;
        end else begin
            s       <= s_next;
            coutfin <= coutfin_next;
            desb    <= desb_next;
        end
    end

endmodule

// File: tb/tb_suma_c2.sv
// tb_suma_c2: directed and random checks of the registered adder at
// ANCHO = 8 and ANCHO = 16.
module tb_suma_c2;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        ci;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic        co8, co16, ov8, ov16;

    int checks   = 0;
    int failures = 0;

    suma_c2 #(.ANCHO(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci),
        .s(s8), .coutfin(co8), .desb(ov8)
    );

    suma_c2 #(.ANCHO(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .ci(ci),
        .s(s16), .coutfin(co16), .desb(ov16)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] es, input logic ec, input logic ev);
        check({name, ".s"},       64'(s8),  64'(es));
        check({name, ".coutfin"}, 64'(co8), 64'(ec));
        check({name, ".desb"},    64'(ov8), 64'(ev));
    endtask

    // Drive on the falling edge, then sample 1 ns after the next rising edge
    task automatic applyStimulus(input logic r, input logic [7:0] va, input logic [7:0] vb, input logic vc);
        @(negedge clk);
        rst_n = r;
        a8    = va;
        b8    = vb;
        ci    = vc;
        a16   = {8'h00, va};
        b16   = {8'h00, vb};
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0]  m8;
        logic [16:0] m16;
        logic        ev8, ev16;
        logic [7:0]  ra8, rb8;
        logic [15:0] ra16, rb16;
        logic        rci;

        vecs[0]  = '{8'h0A, 8'h05, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6]  = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[7]  = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[8]  = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[9]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[10] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; ci = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF;

        // Reset held for two edges with all-ones operands
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1);
            check8("reset", 8'h00, 1'b0, 1'b0);
            check("reset16.s", 64'(s16), 64'h0);
        end

        // Directed table
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci);
            check8($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov);
        end

        // Back-to-back pipeline with a one-edge reset in the middle
        applyStimulus(1'b1, 8'h01, 8'h01, 1'b0);
        check8("pipe0", 8'h02, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h10, 8'h20, 1'b0);
        check8("pipe_rst", 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h10, 8'h20, 1'b0);
        check8("pipe1", 8'h30, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hF0, 8'h0F, 1'b1);
        check8("pipe2", 8'h00, 1'b1, 1'b0);

        // Reset lowered between edges must not touch the outputs until the edge
        applyStimulus(1'b1, 8'h7F, 8'h7F, 1'b1);
        check8("pre_async", 8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check8("async_hold", 8'hFF, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check8("async_edge", 8'h00, 1'b0, 1'b0);

        // Random operands on both widths against an arithmetic model
        for (int i = 0; i < 1000; i++) begin
            ra8  = 8'($urandom);
            rb8  = 8'($urandom);
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            rci  = 1'($urandom);
            @(negedge clk);
            rst_n = 1'b1;
            a8 = ra8; b8 = rb8; a16 = ra16; b16 = rb16; ci = rci;
            m8   = 9'(ra8) + 9'(rb8) + 9'(rci);
            m16  = 17'(ra16) + 17'(rb16) + 17'(rci);
            ev8  = (ra8[7] == rb8[7]) && (m8[7] != ra8[7]);
            ev16 = (ra16[15] == rb16[15]) && (m16[15] != ra16[15]);
            @(posedge clk);
            #1;
            check("rand8.s",       64'(s8),   64'(m8[7:0]));
            check("rand8.coutfin", 64'(co8),  64'(m8[8]));
            check("rand8.desb",    64'(ov8),  64'(ev8));
            check("rand16.s",       64'(s16),  64'(m16[15:0]));
            check("rand16.coutfin", 64'(co16), 64'(m16[16]));
            check("rand16.desb",    64'(ov16), 64'(ev16));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
